// File: rtl/pwm_multi_ctrl_pkg.sv
// Shared types and helpers for the multi-channel PWM controller.
// Duty arithmetic is width-generic so every channel width can reuse it.
package pwm_pkg;

    localparam int unsigned DUTY_W_DEFAULT = 8;
    localparam int unsigned PERIOD         = 2 ** DUTY_W_DEFAULT;

    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_UP   = 2'd1,
        OP_DN   = 2'd2
    } duty_op_e;

    // Ceiling log2, never below 1 so a single channel still gets a select bit.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        w = 0;
        while ((32'd1 << w) < n) w++;
        return (w == 0) ? 1 : w;
    endfunction

    // One extra bit above the duty width catches the carry or borrow before masking.
    function automatic logic [31:0] sat_add(input logic [31:0]  a,
                                            input logic [31:0]  step,
                                            input logic         sub,
                                            input int unsigned  width,
                                            input bit           saturate);
        logic [32:0] max_v;
        logic [32:0] r;
        max_v = (33'd1 << width) - 33'd1;
        if (sub) begin
            r = {1'b0, a} - {1'b0, step};
            if (saturate && (step > a)) r = '0;
        end else begin
            r = {1'b0, a} + {1'b0, step};
            if (saturate && (r > max_v)) r = max_v;
        end
        return 32'(r & max_v);
    endfunction

endpackage

// File: rtl/pwm_multi_ctrl_if.sv
// Control/status bundle between the user-input side and the PWM controller.
interface pwm_multi_ctrl_if
    import pwm_pkg::*;
#(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned DUTY_W   = 8
);
    localparam int unsigned SEL_W = clog2(CHANNELS);

    logic                up_pulse;
    logic                dn_pulse;
    logic                sel_next;
    logic [CHANNELS-1:0] pwm_out;
    logic                pwm_tick;
    logic                period_start;
    logic [SEL_W-1:0]    sel;
    logic [DUTY_W-1:0]   sel_duty;

    modport master (
        output up_pulse, dn_pulse, sel_next,
        input  pwm_out, pwm_tick, period_start, sel, sel_duty
    );

    modport slave (
        input  up_pulse, dn_pulse, sel_next,
        output pwm_out, pwm_tick, period_start, sel, sel_duty
    );

endinterface

// File: rtl/pwm_multi_ctrl_channel.sv
// One PWM channel: requested duty, period-aligned shadow copy and registered compare.
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int unsigned DUTY_W   = 8,
    parameter int unsigned STEP     = 5,
    parameter int unsigned SATURATE = 1
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  duty_op_e          op,
    input  logic              load,
    input  logic [DUTY_W-1:0] counter,
    output logic [DUTY_W-1:0] duty,
    output logic              pwm
);

    logic [DUTY_W-1:0] shadow;
    logic [DUTY_W-1:0] duty_next;

    always_comb begin
        duty_next = DUTY_W'(sat_add(32'(duty), 32'(STEP), op == OP_DN, DUTY_W, SATURATE != 0));
    end

    // The shadow only follows duty at the wrap, so a period never mixes two duty values.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            duty   <= '0;
            shadow <= '0;
            pwm    <= 1'b0;
        end else begin
            if (op != OP_HOLD) duty <= duty_next;
            if (load)          shadow <= duty;
            pwm <= (counter < shadow);
        end
    end

endmodule

// File: rtl/pwm_multi_ctrl.sv
// Multi-channel PWM generator: prescaler, shared period counter, channel select
// and per-channel duty stepping driven by one-cycle user pulses.
module pwm_multi_ctrl
    import pwm_pkg::*;
#(
    parameter int unsigned CHANNELS   = 4,
    parameter int unsigned DUTY_W     = DUTY_W_DEFAULT,
    parameter int unsigned PRESCALE_W = 7,
    parameter int unsigned STEP       = 5,
    parameter int unsigned SATURATE   = 1
) (
    input  logic            CLK,
    input  logic            RESET_N,
    pwm_multi_ctrl_if.slave bus
);

    localparam int unsigned SEL_W = clog2(CHANNELS);

    logic [PRESCALE_W-1:0] presc;
    logic [DUTY_W-1:0]     counter;
    logic                  pwm_tick_q;
    logic                  period_start_q;
    logic [SEL_W-1:0]      sel_q;
    logic [DUTY_W-1:0]     sel_duty_c;
    duty_op_e              req_op;
    duty_op_e              ch_op   [CHANNELS];
    logic [DUTY_W-1:0]     ch_duty [CHANNELS];
    logic [CHANNELS-1:0]   ch_pwm;

    // period_start is decided one cycle early, together with pwm_tick, so it
    // coincides with the tick that takes the counter from all-ones to zero.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            presc          <= '0;
            pwm_tick_q     <= 1'b0;
            period_start_q <= 1'b0;
            counter        <= '0;
        end else begin
            presc          <= presc + PRESCALE_W'(1);
            pwm_tick_q     <= &presc;
            period_start_q <= (&presc) && (&counter);
            if (pwm_tick_q) counter <= counter + DUTY_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sel_q <= '0;
        end else if (bus.sel_next) begin
            sel_q <= (sel_q == SEL_W'(CHANNELS - 1)) ? '0 : sel_q + SEL_W'(1);
        end
    end

    always_comb begin
        req_op = OP_HOLD;
        if (bus.up_pulse && !bus.dn_pulse) req_op = OP_UP;
        if (bus.dn_pulse && !bus.up_pulse) req_op = OP_DN;
    end

    // Decode against the pre-advance select so a coincident sel_next hits the old channel.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        assign ch_op[i] = (sel_q == SEL_W'(i)) ? req_op : OP_HOLD;

        pwm_channel #(
            .DUTY_W   (DUTY_W),
            .STEP     (STEP),
            .SATURATE (SATURATE)
        ) u_ch (
            .CLK     (CLK),
            .RESET_N (RESET_N),
            .op      (ch_op[i]),
            .load    (period_start_q),
            .counter (counter),
            .duty    (ch_duty[i]),
            .pwm     (ch_pwm[i])
        );
    end

    always_comb begin
        sel_duty_c = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (sel_q == SEL_W'(i)) sel_duty_c = ch_duty[i];
        end
    end

    assign bus.pwm_out      = ch_pwm;
    assign bus.pwm_tick     = pwm_tick_q;
    assign bus.period_start = period_start_q;
    assign bus.sel          = sel_q;
    assign bus.sel_duty     = sel_duty_c;

endmodule

// File: tb/tb_pwm_multi_ctrl.sv
// Directed bench for pwm_multi_ctrl: a saturating and a wrapping instance share stimulus.
module tb_pwm_multi_ctrl;
    import pwm_pkg::*;

    localparam int unsigned CH      = 4;
    localparam int unsigned DW      = 8;
    localparam int unsigned PW      = 2;
    localparam int unsigned PER_CLK = PERIOD * (1 << PW);

    logic CLK     = 1'b0;
    logic RESET_N = 1'b0;
    logic up      = 1'b0;
    logic dn      = 1'b0;
    logic nxt     = 1'b0;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;
    int unsigned hs [CH];
    int unsigned hw [CH];
    int unsigned rs [CH];

    always #5 CLK = ~CLK;

    pwm_multi_ctrl_if #(.CHANNELS(CH), .DUTY_W(DW)) bus_s ();
    pwm_multi_ctrl_if #(.CHANNELS(CH), .DUTY_W(DW)) bus_w ();

    assign bus_s.up_pulse = up;
    assign bus_s.dn_pulse = dn;
    assign bus_s.sel_next = nxt;
    assign bus_w.up_pulse = up;
    assign bus_w.dn_pulse = dn;
    assign bus_w.sel_next = nxt;

    pwm_multi_ctrl #(
        .CHANNELS(CH), .DUTY_W(DW), .PRESCALE_W(PW), .STEP(5), .SATURATE(1)
    ) dut_s (
        .CLK(CLK), .RESET_N(RESET_N), .bus(bus_s.slave)
    );

    pwm_multi_ctrl #(
        .CHANNELS(CH), .DUTY_W(DW), .PRESCALE_W(PW), .STEP(5), .SATURATE(0)
    ) dut_w (
        .CLK(CLK), .RESET_N(RESET_N), .bus(bus_w.slave)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse(input logic u, input logic d, input logic s, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            up = u; dn = d; nxt = s;
            tick();
        end
        up = 1'b0; dn = 1'b0; nxt = 1'b0;
    endtask

    task automatic wait_ps();
        bit ok;
        ok = 1'b0;
        for (int unsigned i = 0; i < 2100 && !ok; i++) begin
            tick();
            if (bus_s.period_start === 1'b1) ok = 1'b1;
        end
        n_total++;
        if (!ok) $display("FAIL wait_period_start: timed out, got no pulse, want a pulse within 2100 cycles");
        else n_pass++;
    endtask

    // Samples the current cycle onward; optionally drives dn over [dn_from, dn_to).
    task automatic count_window(input int unsigned ncyc, input int unsigned dn_from,
                                input int unsigned dn_to);
        logic [CH-1:0] prev;
        prev = '0;
        for (int unsigned c = 0; c < CH; c++) begin
            hs[c] = 0; hw[c] = 0; rs[c] = 0;
        end
        for (int unsigned i = 0; i < ncyc; i++) begin
            for (int unsigned c = 0; c < CH; c++) begin
                if (bus_s.pwm_out[c] === 1'b1) hs[c]++;
                if (bus_w.pwm_out[c] === 1'b1) hw[c]++;
                if (bus_s.pwm_out[c] === 1'b1 && !prev[c]) rs[c]++;
            end
            prev = bus_s.pwm_out;
            if (i == dn_from) dn = 1'b1;
            if (i == dn_to)   dn = 1'b0;
            tick();
        end
        dn = 1'b0;
    endtask

    task automatic do_reset();
        RESET_N = 1'b0;
        tick();
        tick();
        RESET_N = 1'b1;
    endtask

    task automatic test_reset();
        RESET_N = 1'b0;
        repeat (3) tick();
        n_total++; if (bus_s.pwm_out !== 4'h0) $display("FAIL rst_pwm_out: got %h want 0", bus_s.pwm_out); else n_pass++;
        n_total++; if (bus_s.pwm_tick !== 1'b0) $display("FAIL rst_pwm_tick: got %b want 0", bus_s.pwm_tick); else n_pass++;
        n_total++; if (bus_s.period_start !== 1'b0) $display("FAIL rst_period_start: got %b want 0", bus_s.period_start); else n_pass++;
        n_total++; if (bus_s.sel !== 2'd0) $display("FAIL rst_sel: got %0d want 0", bus_s.sel); else n_pass++;
        n_total++; if (bus_s.sel_duty !== 8'd0) $display("FAIL rst_sel_duty: got %0d want 0", bus_s.sel_duty); else n_pass++;
        n_total++; if (bus_w.pwm_out !== 4'h0) $display("FAIL rst_pwm_out_wrap: got %h want 0", bus_w.pwm_out); else n_pass++;
        RESET_N = 1'b1;
    endtask

    task automatic test_idle();
        int unsigned ticks, gap_bad, ps_cnt, ps_first, ps_second, hi, last_tick;
        ticks = 0; gap_bad = 0; ps_cnt = 0; ps_first = 0; ps_second = 0; hi = 0; last_tick = 0;
        for (int unsigned i = 1; i <= 2200; i++) begin
            tick();
            if (bus_s.pwm_out !== 4'h0 || bus_w.pwm_out !== 4'h0) hi++;
            if (bus_s.pwm_tick === 1'b1) begin
                if (ticks > 0 && (i - last_tick) != 4) gap_bad++;
                ticks++;
                last_tick = i;
            end
            if (bus_s.period_start === 1'b1) begin
                if (ps_cnt == 0) ps_first = i;
                if (ps_cnt == 1) ps_second = i;
                ps_cnt++;
            end
        end
        n_total++; if (hi != 0) $display("FAIL idle_pwm_low: got %0d high cycles want 0", hi); else n_pass++;
        n_total++; if (ticks != 550) $display("FAIL idle_tick_count: got %0d want 550", ticks); else n_pass++;
        n_total++; if (gap_bad != 0) $display("FAIL idle_tick_spacing: got %0d bad gaps want 0", gap_bad); else n_pass++;
        n_total++; if (ps_cnt != 2) $display("FAIL idle_ps_count: got %0d want 2", ps_cnt); else n_pass++;
        n_total++; if (ps_first != 1024) $display("FAIL idle_ps_first: got cycle %0d want 1024", ps_first); else n_pass++;
        n_total++; if (ps_second - ps_first != PER_CLK) $display("FAIL idle_ps_interval: got %0d want %0d", ps_second - ps_first, PER_CLK); else n_pass++;
    endtask

    task automatic test_duty_up();
        pulse(1'b1, 1'b0, 1'b0, 10);
        n_total++; if (bus_s.sel_duty !== 8'd50) $display("FAIL up10_sel_duty: got %0d want 50", bus_s.sel_duty); else n_pass++;
        wait_ps();
        tick(); tick();
        count_window(PER_CLK, PER_CLK, PER_CLK);
        n_total++; if (hs[0] != 200) $display("FAIL up10_high_clk: got %0d want 200", hs[0]); else n_pass++;
        n_total++; if (rs[0] != 1) $display("FAIL up10_rises: got %0d want 1", rs[0]); else n_pass++;
        n_total++; if (hs[1] + hs[2] + hs[3] != 0) $display("FAIL up10_other_ch: got %0d want 0", hs[1] + hs[2] + hs[3]); else n_pass++;
    endtask

    task automatic test_saturate();
        do_reset();
        pulse(1'b1, 1'b0, 1'b0, 52);
        n_total++; if (bus_s.sel_duty !== 8'd255) $display("FAIL sat_up_clamp: got %0d want 255", bus_s.sel_duty); else n_pass++;
        n_total++; if (bus_w.sel_duty !== 8'd4) $display("FAIL wrap_up: got %0d want 4", bus_w.sel_duty); else n_pass++;
        wait_ps();
        tick(); tick();
        count_window(PER_CLK, PER_CLK, PER_CLK);
        n_total++; if (hs[0] != 1020) $display("FAIL sat_255_high_clk: got %0d want 1020", hs[0]); else n_pass++;
        n_total++; if (hw[0] != 16) $display("FAIL wrap_4_high_clk: got %0d want 16", hw[0]); else n_pass++;
        pulse(1'b0, 1'b1, 1'b0, 60);
        n_total++; if (bus_s.sel_duty !== 8'd0) $display("FAIL sat_dn_clamp: got %0d want 0", bus_s.sel_duty); else n_pass++;
        n_total++; if (bus_w.sel_duty !== 8'd216) $display("FAIL wrap_dn: got %0d want 216", bus_w.sel_duty); else n_pass++;
        wait_ps();
        tick(); tick();
        count_window(PER_CLK, PER_CLK, PER_CLK);
        n_total++; if (hs[0] != 0) $display("FAIL sat_0_high_clk: got %0d want 0", hs[0]); else n_pass++;
        n_total++; if (hw[0] != 864) $display("FAIL wrap_216_high_clk: got %0d want 864", hw[0]); else n_pass++;
    endtask

    task automatic test_simultaneous();
        pulse(1'b1, 1'b0, 1'b0, 20);
        n_total++; if (bus_s.sel_duty !== 8'd100) $display("FAIL simul_setup: got %0d want 100", bus_s.sel_duty); else n_pass++;
        pulse(1'b1, 1'b1, 1'b0, 3);
        n_total++; if (bus_s.sel_duty !== 8'd100) $display("FAIL simul_updn_hold: got %0d want 100", bus_s.sel_duty); else n_pass++;
        pulse(1'b0, 1'b0, 1'b1, 3);
        n_total++; if (bus_s.sel !== 2'd3) $display("FAIL simul_sel3: got %0d want 3", bus_s.sel); else n_pass++;
        pulse(1'b1, 1'b0, 1'b1, 1);
        n_total++; if (bus_s.sel !== 2'd0) $display("FAIL simul_sel_wrap: got %0d want 0", bus_s.sel); else n_pass++;
        n_total++; if (bus_s.sel_duty !== 8'd100) $display("FAIL simul_ch0_untouched: got %0d want 100", bus_s.sel_duty); else n_pass++;
        pulse(1'b0, 1'b0, 1'b1, 3);
        n_total++; if (bus_s.sel_duty !== 8'd5) $display("FAIL simul_ch3_stepped: got %0d want 5", bus_s.sel_duty); else n_pass++;
    endtask

    task automatic test_midperiod();
        pulse(1'b0, 1'b0, 1'b1, 1);
        pulse(1'b0, 1'b1, 1'b0, 10);
        n_total++; if (bus_s.sel_duty !== 8'd50) $display("FAIL mid_setup: got %0d want 50", bus_s.sel_duty); else n_pass++;
        wait_ps();
        tick(); tick();
        // Counter sits at 30 around window cycles 119..122; eight dn pulses take 50 to 10.
        count_window(PER_CLK, 119, 127);
        n_total++; if (bus_s.sel_duty !== 8'd10) $display("FAIL mid_sel_duty: got %0d want 10", bus_s.sel_duty); else n_pass++;
        n_total++; if (hs[0] != 200) $display("FAIL mid_cur_period: got %0d want 200", hs[0]); else n_pass++;
        n_total++; if (rs[0] != 1) $display("FAIL mid_cur_rises: got %0d want 1", rs[0]); else n_pass++;
        count_window(PER_CLK, PER_CLK, PER_CLK);
        n_total++; if (hs[0] != 40) $display("FAIL mid_next_period: got %0d want 40", hs[0]); else n_pass++;
        n_total++; if (rs[0] != 1) $display("FAIL mid_next_rises: got %0d want 1", rs[0]); else n_pass++;
    endtask

    task automatic test_reset_mid();
        pulse(1'b0, 1'b0, 1'b1, 1);
        pulse(1'b1, 1'b0, 1'b0, 4);
        n_total++; if (bus_s.sel_duty !== 8'd20) $display("FAIL rmid_setup: got %0d want 20", bus_s.sel_duty); else n_pass++;
        wait_ps();
        repeat (20) tick();
        n_total++; if (bus_s.pwm_out[1] !== 1'b1) $display("FAIL rmid_pwm1_high: got %b want 1", bus_s.pwm_out[1]); else n_pass++;
        #2 RESET_N = 1'b0;
        #1;
        n_total++; if (bus_s.pwm_out !== 4'h0) $display("FAIL rmid_async_drop: got %h want 0", bus_s.pwm_out); else n_pass++;
        n_total++; if (bus_s.sel !== 2'd0) $display("FAIL rmid_sel: got %0d want 0", bus_s.sel); else n_pass++;
        tick(); tick();
        RESET_N = 1'b1;
        tick();
        for (int unsigned k = 0; k < CH; k++) begin
            n_total++;
            if (bus_s.sel_duty !== 8'd0) $display("FAIL rmid_duty_ch%0d: got %0d want 0", k, bus_s.sel_duty);
            else n_pass++;
            pulse(1'b0, 1'b0, 1'b1, 1);
        end
        count_window(PER_CLK, PER_CLK, PER_CLK);
        n_total++; if (hs[0] + hs[1] + hs[2] + hs[3] != 0) $display("FAIL rmid_first_period_low: got %0d want 0", hs[0] + hs[1] + hs[2] + hs[3]); else n_pass++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion, want finish before 2000000");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_idle();
        test_duty_up();
        test_saturate();
        test_simultaneous();
        test_midperiod();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
